// File: rtl/decode_pipe_stage.sv
// Decode stage with its own ID/EX register.
// It selects the source addresses and reads a 31-entry GPR file, where R31
// reads back as PC+16. It extends the immediate and registers the result
// behind a valid/ready handshake. The handshake includes flush, a same-cycle
// write-back bypass and a refresh of held operands during a stall.

// One combinational read port: R31 -> PC+16, then write-back bypass, then storage.
module decode_read_port #(
    parameter int WIDTH = 64
) (
    input  logic [4:0]             addr,
    input  logic [30:0][WIDTH-1:0] gpr,
    input  logic [WIDTH-1:0]       pc_plus16,
    input  logic                   reg_write,
    input  logic [4:0]             wa3,
    input  logic [WIDTH-1:0]       result,
    output logic [WIDTH-1:0]       rd
);

    // priority read mux; the write to R31 never bypasses because R31 is not storage
    always_comb begin
        rd = '0;
        if (addr == 5'd31) begin
            rd = pc_plus16;
        end else if (reg_write && (addr == wa3)) begin
            rd = result;
        end else begin
            for (int i = 0; i < 31; i++) begin
                if (addr == 5'(i)) rd = gpr[i];
            end
        end
    end

endmodule

module decode_pipe_stage #(
    parameter int WIDTH   = 64,
    parameter int INSTR_W = 64,
    parameter int IMM_W   = 24
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    input  logic [INSTR_W-1:0] instr_d,
    input  logic [WIDTH-1:0]   pc_plus16_d,
    input  logic [1:0]         reg_src_d,
    input  logic               imm_src_d,
    input  logic               reg_write_w,
    input  logic [4:0]         wa3_w,
    input  logic [WIDTH-1:0]   result_w,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   rd1_e,
    output logic [WIDTH-1:0]   rd2_e,
    output logic [WIDTH-1:0]   ext_imm_e,
    output logic [4:0]         ra1_e,
    output logic [4:0]         ra2_e
);

    typedef struct packed {
        logic [WIDTH-1:0] rd1;
        logic [WIDTH-1:0] rd2;
        logic [WIDTH-1:0] ext_imm;
        logic [4:0]       ra1;
        logic [4:0]       ra2;
    } idex_t;

    logic [30:0][WIDTH-1:0] gpr_q, gpr_d;
    idex_t                  idex_q, idex_d;
    logic                   out_valid_q, out_valid_d;

    logic [1:0][4:0]        ra;
    logic [1:0][WIDTH-1:0]  rd;
    logic [WIDTH-1:0]       ext_imm;
    logic                   capture;
    logic                   stall;

    // only a few instruction fields are decoded here
    logic                   unused_instr;
    assign unused_instr = ^instr_d;

    // source address select
    always_comb begin
        ra[0] = reg_src_d[0] ? 5'd31 : instr_d[51:47];
        ra[1] = reg_src_d[1] ? instr_d[46:42] : instr_d[4:0];
    end

    decode_read_port #(.WIDTH(WIDTH)) u_rp [1:0] (
        .addr      (ra),
        .gpr       (gpr_q),
        .pc_plus16 (pc_plus16_d),
        .reg_write (reg_write_w),
        .wa3       (wa3_w),
        .result    (result_w),
        .rd        (rd)
    );

    // zero- or sign-extend the low IMM_W instruction bits
    always_comb begin
        ext_imm = '0;
        ext_imm[IMM_W-1:0] = instr_d[IMM_W-1:0];
        for (int i = IMM_W; i < WIDTH; i++) begin
            ext_imm[i] = imm_src_d & instr_d[IMM_W-1];
        end
    end

    // handshake: the slot frees when empty or when execute drains it
    assign in_ready = !out_valid_q || out_ready;
    assign capture  = in_valid && in_ready && !flush;
    assign stall    = out_valid_q && !out_ready && !flush;

    // GPR write; R31 is not storage, so writes to it are dropped
    always_comb begin
        gpr_d = gpr_q;
        if (reg_write_w) begin
            for (int i = 0; i < 31; i++) begin
                if (wa3_w == 5'(i)) gpr_d[i] = result_w;
            end
        end
    end

    // ID/EX next state: flush > capture > refresh of held operands
    always_comb begin
        idex_d      = idex_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (capture) begin
            out_valid_d    = 1'b1;
            idex_d.rd1     = rd[0];
            idex_d.rd2     = rd[1];
            idex_d.ext_imm = ext_imm;
            idex_d.ra1     = ra[0];
            idex_d.ra2     = ra[1];
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        // a held instruction must not carry stale operands into execute
        if (stall && reg_write_w) begin
            if ((wa3_w == idex_q.ra1) && (idex_q.ra1 != 5'd31)) idex_d.rd1 = result_w;
            if ((wa3_w == idex_q.ra2) && (idex_q.ra2 != 5'd31)) idex_d.rd2 = result_w;
        end
    end

    // state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpr_q       <= '0;
            idex_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            gpr_q       <= gpr_d;
            idex_q      <= idex_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign rd1_e     = idex_q.rd1;
    assign rd2_e     = idex_q.rd2;
    assign ext_imm_e = idex_q.ext_imm;
    assign ra1_e     = idex_q.ra1;
    assign ra2_e     = idex_q.ra2;

endmodule
